// File: rtl/timer_irq_peripheral.sv
// -----------------------------------------------------------------------------
// timer_irq_peripheral
//
// Memory-mapped timer that sits on the CPU's MEM-stage load/store bus next to
// the data memory and drives the CPU's interrupt input.
//
// Function:
//   - Reloadable 32-bit up-counter (TL) that advances once every PRESCALE
//     enabled clock cycles. On overflow (TL == 0xFFFFFFFF) it reloads from TH
//     and, if interrupts are enabled, latches the overflow flag IF.
//   - Free-running 32-bit cycle counter (SYSTICK), independent of EN.
//   - Level interrupt request IRQ, registered from IE & IF.
//
// Register window (32 bytes at BASE_ADDR, Address[1:0] ignored):
//   0x00 TH       reload value              (RW)
//   0x04 TL       count; store clears prescaler (RW)
//   0x08 TCON     [0] EN, [1] IE, [2] IF    (RW; IF can only be cleared by SW)
//   0x0C PRE      prescaler phase           (RO)
//   0x10 SYSTICK  free-running cycle count  (RO)
//   0x14-0x1C     read 0, stores ignored
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   reset       asynchronous, active-low reset
//   Address     byte address of the current MEM-stage access
//   Write_data  store data
//   MemRead     load strobe
//   MemWrite    store strobe
//   hit         Address falls inside the register window (combinational)
//   Read_data   load data, combinational, 0 unless hit && MemRead
//   IRQ         interrupt request, registered level
//
// Bus timing: MemRead and MemWrite are single-cycle strobes with no handshake
// and no wait states. A load returns data combinationally in the same cycle
// from the registers' current (pre-edge) values. A store is committed at the
// rising edge that ends the cycle in which MemWrite && hit is seen. When both
// strobes are high the store is committed and the load still shows the
// pre-edge value.
// -----------------------------------------------------------------------------
module timer_irq_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        hit,
    output logic [31:0] Read_data,
    output logic        IRQ
);

    // Last prescaler phase; the cycle the prescaler sits here is a tick.
    localparam logic [31:0] PRE_LAST = 32'(PRESCALE - 1);

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_PRE     = 3'd3;
    localparam logic [2:0] OFF_SYSTICK = 3'd4;

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] th_q,  th_d;
    logic [31:0] tl_q,  tl_d;
    logic [31:0] pre_q, pre_d;
    logic [31:0] systick_q;
    logic        en_q,  en_d;
    logic        ie_q,  ie_d;
    logic        if_q,  if_d;
    logic        irq_q, irq_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [2:0] offset;
    logic       store;
    logic       wr_th;
    logic       wr_tl;
    logic       wr_tcon;

    // Byte-lane bits play no part in register selection.
    logic unused_byte_lane;
    assign unused_byte_lane = ^Address[1:0];

    assign hit     = (Address[31:5] == BASE_ADDR[31:5]);
    assign offset  = Address[4:2];
    assign store   = MemWrite && hit;
    assign wr_th   = store && (offset == OFF_TH);
    assign wr_tl   = store && (offset == OFF_TL);
    assign wr_tcon = store && (offset == OFF_TCON);

    // ------------------------------------------------------------------
    // Counting events
    // ------------------------------------------------------------------
    logic tick;
    logic overflow;

    assign tick     = en_q && (pre_q == PRE_LAST);
    assign overflow = tick && (tl_q == TL_MAX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        th_d  = th_q;
        tl_d  = tl_q;
        pre_d = pre_q;
        en_d  = en_q;
        ie_d  = ie_q;
        if_d  = if_q;

        // Prescaler only moves while enabled; disabling it freezes the phase.
        if (en_q) begin
            pre_d = tick ? 32'd0 : pre_q + 32'd1;
        end

        // Reload takes the pre-edge TH, so a TH store on the overflow edge
        // only affects the following overflow.
        if (tick) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end

        if (wr_th) begin
            th_d = Write_data;
        end

        // A TL store overrides whatever the counter was about to do.
        if (wr_tl) begin
            tl_d  = Write_data;
            pre_d = 32'd0;
        end

        if (wr_tcon) begin
            en_d = Write_data[0];
            ie_d = Write_data[1];
            if (!Write_data[2]) begin
                if_d = 1'b0;
            end
        end

        // Hardware set is applied after the software clear so an overflow
        // coinciding with a clear is never lost. A TL store on the same edge
        // cancels the overflow entirely, including its flag.
        if (overflow && ie_q && !wr_tl) begin
            if_d = 1'b1;
        end
    end

    // IRQ follows the stored flag with one cycle of lag: it rises on the
    // edge after IF is set and falls on the edge after IF or IE is cleared.
    assign irq_d = ie_q && if_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= 32'd0;
            tl_q      <= 32'd0;
            pre_q     <= 32'd0;
            systick_q <= 32'd0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            if_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            pre_q     <= pre_d;
            systick_q <= systick_q + 32'd1;
            en_q      <= en_d;
            ie_q      <= ie_d;
            if_q      <= if_d;
            irq_q     <= irq_d;
        end
    end

    assign IRQ = irq_q;

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = 32'd0;
        case (offset)
            OFF_TH:      rd_mux = th_q;
            OFF_TL:      rd_mux = tl_q;
            OFF_TCON:    rd_mux = {29'd0, if_q, ie_q, en_q};
            OFF_PRE:     rd_mux = pre_q;
            OFF_SYSTICK: rd_mux = systick_q;
            default:     rd_mux = 32'd0;
        endcase
    end

    assign Read_data = (hit && MemRead) ? rd_mux : 32'd0;

endmodule

// File: tb/tb_timer_irq_peripheral.sv
// -----------------------------------------------------------------------------
// tb_timer_irq_peripheral
//
// Two timers share one bus: dut1 with PRESCALE=1 and dut4 with PRESCALE=4.
// A register-level model of each timer is advanced on every clock edge from
// the bus inputs alone; a compare process checks hit, Read_data and IRQ of
// both instances against it on every falling edge. Directed sequences add
// hand-computed literal expectations at the points of interest.
// -----------------------------------------------------------------------------
module tb_timer_irq_peripheral;

    localparam logic [31:0] BASE    = 32'h4000_0000;
    localparam logic [31:0] A_TH    = BASE + 32'h00;
    localparam logic [31:0] A_TL    = BASE + 32'h04;
    localparam logic [31:0] A_TCON  = BASE + 32'h08;
    localparam logic [31:0] A_PRE   = BASE + 32'h0C;
    localparam logic [31:0] A_SYS   = BASE + 32'h10;
    localparam logic [31:0] A_RSVD  = BASE + 32'h1C;
    localparam logic [31:0] A_OUT   = BASE + 32'h20;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] Address    = 32'd0;
    logic [31:0] Write_data = 32'd0;
    logic        MemRead    = 1'b0;
    logic        MemWrite   = 1'b0;

    logic        hit1, hit4, irq1, irq4;
    logic [31:0] rd1, rd4;

    timer_irq_peripheral #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .hit        (hit1),
        .Read_data  (rd1),
        .IRQ        (irq1)
    );

    timer_irq_peripheral #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .hit        (hit4),
        .Read_data  (rd4),
        .IRQ        (irq4)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: register contents of one timer
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] th;
        logic [31:0] tl;
        logic [31:0] pre;
        logic [31:0] sys;
        logic        en;
        logic        ie;
        logic        iflag;
        logic        irq;
    } mstate_t;

    mstate_t m1, m4;

    function automatic mstate_t model_zero();
        mstate_t z;
        z.th = 0; z.tl = 0; z.pre = 0; z.sys = 0;
        z.en = 0; z.ie = 0; z.iflag = 0; z.irq = 0;
        return z;
    endfunction

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    // One clock edge: the counter event happens first, then the bus store
    // overrides the affected registers, then the overflow flag is applied.
    function automatic mstate_t model_next(input mstate_t s, input int p,
                                           input logic [31:0] a, input logic [31:0] wd,
                                           input logic we);
        mstate_t n = s;
        bit      do_tick, ovf, st;
        int      reg_idx;
        do_tick = s.en && (s.pre == 32'(p - 1));
        ovf     = do_tick && (s.tl == 32'hFFFF_FFFF);
        st      = we && in_window(a);
        reg_idx = int'((a - BASE) >> 2) & 7;

        n.sys = s.sys + 1;
        n.irq = s.ie & s.iflag;
        if (s.en) n.pre = do_tick ? 0 : s.pre + 1;
        if (do_tick) n.tl = ovf ? s.th : s.tl + 1;

        if (st && reg_idx == 0) n.th = wd;
        if (st && reg_idx == 1) begin
            n.tl  = wd;
            n.pre = 0;
            ovf   = 0;
        end
        if (st && reg_idx == 2) begin
            n.en = wd[0];
            n.ie = wd[1];
            if (!wd[2]) n.iflag = 0;
        end
        if (ovf && s.ie) n.iflag = 1;
        return n;
    endfunction

    function automatic logic [31:0] model_read(input mstate_t s, input logic [31:0] a,
                                               input logic rd);
        if (!(rd && in_window(a))) return 32'd0;
        case ((a - BASE) >> 2)
            32'd0:   return s.th;
            32'd1:   return s.tl;
            32'd2:   return {29'd0, s.iflag, s.ie, s.en};
            32'd3:   return s.pre;
            32'd4:   return s.sys;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        m1 = model_zero();
        m4 = model_zero();
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m1 <= model_zero();
            m4 <= model_zero();
        end else begin
            m1 <= model_next(m1, 1, Address, Write_data, MemWrite);
            m4 <= model_next(m4, 4, Address, Write_data, MemWrite);
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        check("hit1",  {31'd0, hit1}, {31'd0, in_window(Address)});
        check("hit4",  {31'd0, hit4}, {31'd0, in_window(Address)});
        check("rdata1", rd1, model_read(m1, Address, MemRead));
        check("rdata4", rd4, model_read(m4, Address, MemRead));
        check("irq1",  {31'd0, irq1}, {31'd0, m1.irq});
        check("irq4",  {31'd0, irq4}, {31'd0, m4.irq});
    end

    // ------------------------------------------------------------------
    // Driver tasks (each starts and ends 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    logic [31:0] s_rd1, s_rd4;
    logic        s_irq1, s_hit1;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Address = a; Write_data = d; MemWrite = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0; Address = 32'd0; Write_data = 32'd0;
    endtask

    task automatic load(input logic [31:0] a);
        Address = a; MemRead = 1'b1;
        @(negedge clk);
        s_rd1 = rd1; s_rd4 = rd4; s_irq1 = irq1; s_hit1 = hit1;
        @(posedge clk); #1;
        MemRead = 1'b0; Address = 32'd0;
    endtask

    task automatic load_store(input logic [31:0] a, input logic [31:0] d);
        Address = a; Write_data = d; MemRead = 1'b1; MemWrite = 1'b1;
        @(negedge clk);
        s_rd1 = rd1; s_rd4 = rd4;
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; Write_data = 32'd0;
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    logic [31:0] v0, v1;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        load(A_TCON);
        check("reset_tcon", s_rd1, 32'd0);
        check("reset_irq", {31'd0, s_irq1}, 32'd0);

        // Overflow, reload and interrupt
        store(A_TH, 32'hFFFF_FFF0);
        store(A_TL, 32'hFFFF_FFFD);
        store(A_TCON, 32'd3);
        load(A_TL); check("t1_tl0", s_rd1, 32'hFFFF_FFFD);
        load(A_TL); check("t1_tl1", s_rd1, 32'hFFFF_FFFE);
        load(A_TL); check("t1_tl2", s_rd1, 32'hFFFF_FFFF);
        load(A_TL); check("t1_reload", s_rd1, 32'hFFFF_FFF0);
        check("t1_irq_lag", {31'd0, s_irq1}, 32'd0);
        load(A_TCON); check("t1_tcon_if", s_rd1, 32'd7);
        check("t1_irq_up", {31'd0, s_irq1}, 32'd1);

        // Software clear of IF
        store(A_TCON, 32'd3);
        load(A_TCON); check("t2_tcon", s_rd1, 32'd3);
        check("t2_irq_down", {31'd0, irq1}, 32'd0);
        load(A_TL); check("t2_counting", s_rd1, 32'hFFFF_FFF4);

        // Prescaler of 4
        store(A_TL, 32'd0);
        for (int k = 0; k < 10; k++) begin
            load(A_TL);
            check("t3_pre4", s_rd4, 32'(k / 4));
        end
        store(A_TL, 32'd5);
        for (int k = 0; k < 6; k++) begin
            load(A_TL);
            check("t3_restart", s_rd4, (k < 4) ? 32'd5 : 32'd6);
        end
        // EN off/on keeps prescaler phase (checked by the per-cycle compare)
        store(A_TCON, 32'd2);
        load(A_PRE);
        idle(2);
        store(A_TCON, 32'd3);
        for (int k = 0; k < 6; k++) load(A_PRE);

        // Overflow coinciding with TCON clear: IF stays set
        store(A_TL, 32'hFFFF_FFFF);
        idle(1);
        store(A_TL, 32'hFFFF_FFFE);
        idle(1);
        store(A_TCON, 32'd3);
        load(A_TCON); check("t4_tcon7", s_rd1, 32'd7);
        check("t4_irq_held", {31'd0, s_irq1}, 32'd1);
        check("t4_irq_after", {31'd0, irq1}, 32'd1);
        // Overflow coinciding with TL store: store wins, IF untouched
        store(A_TCON, 32'd3);
        store(A_TL, 32'hFFFF_FFFF);
        store(A_TL, 32'h0000_0100);
        load(A_TL); check("t4_tl_store", s_rd1, 32'h0000_0100);
        load(A_TCON); check("t4_if_clear", s_rd1, 32'd3);
        check("t4_irq_low", {31'd0, s_irq1}, 32'd0);

        // Asynchronous reset mid-cycle
        store(A_TL, 32'hFFFF_FFFF);
        idle(1);
        store(A_TCON, 32'd6);
        store(A_TL, 32'h0000_1234);
        load(A_TL); check("t5_tl_pre", s_rd1, 32'h0000_1234);
        check("t5_irq_pre", {31'd0, irq1}, 32'd1);
        Address = A_TL; MemRead = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("t5_tl_zero", rd1, 32'd0);
        check("t5_irq_zero", {31'd0, irq1}, 32'd0);
        check("t5_hit", {31'd0, hit1}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            Address = BASE + 32'(k * 4);
            #1;
            check("t5_reg1_zero", rd1, 32'd0);
            check("t5_reg4_zero", rd4, 32'd0);
        end
        MemRead = 1'b0; Address = 32'd0;
        idle(2);
        reset = 1'b1;
        load(A_SYS); check("t5_sys0", s_rd1, 32'd0);
        load(A_SYS); check("t5_sys1", s_rd1, 32'd1);
        load(A_TL);  check("t5_no_count", s_rd1, 32'd0);

        // SYSTICK delta, out-of-window, reserved, read+write
        load(A_SYS); v0 = s_rd1;
        idle(9);
        load(A_SYS); v1 = s_rd4;
        check("t6_sys_delta", v1 - v0, 32'd10);
        load(A_OUT);
        check("t6_out_hit", {31'd0, s_hit1}, 32'd0);
        check("t6_out_rdata", s_rd1, 32'd0);
        store(A_OUT, 32'hDEAD_BEEF);
        load(A_TH); check("t6_out_nowrite", s_rd1, 32'd0);
        store(A_RSVD, 32'hFFFF_FFFF);
        load(A_RSVD); check("t6_rsvd", s_rd1, 32'd0);
        load_store(A_TL, 32'h0000_0055);
        check("t6_rw_old", s_rd1, 32'd0);
        load(A_TL); check("t6_rw_new", s_rd1, 32'h0000_0055);

        idle(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
